// File: rtl/usbf_wb_slave_if.sv
// ---------------------------------------------------------------------------
// usbf_wb_slave_if
//
// Wishbone classic slave front end for the USB function core register space.
// Each accepted wb_cyc_i & wb_stb_i cycle becomes a one-cycle read or write
// strobe towards the core. The block then waits for the core's reg_rdy_i
// handshake, whose latency varies. It terminates the bus cycle with
// wb_ack_o. If the wait runs past TIMEOUT cycles, it terminates with
// wb_err_o instead and bumps a saturating error counter.
//
// Parameters
//   ADDR_W   address width
//   DATA_W   data width (multiple of 8)
//   TIMEOUT  maximum wait cycles for reg_rdy_i, 0 disables the timeout
//
// Ports
//   clk_i, wb_rst_n         clock, asynchronous active-low reset
//   wb_addr_i/data_i/sel_i  Wishbone request address, write data, byte selects
//   wb_we_i/stb_i/cyc_i     Wishbone request qualifiers
//   wb_data_o               registered read data (all-ones after a timeout)
//   wb_ack_o / wb_err_o     one-cycle normal / timeout termination
//   reg_addr_o/wdata_o/sel_o  request fields latched at acceptance
//   reg_we_o / reg_re_o     one-cycle write / read strobes to the core
//   reg_rdata_i, reg_rdy_i  core read data and completion pulse
//   busy_o                  high while a transfer is in progress
//   err_cnt_o               saturating count of timeouts
// ---------------------------------------------------------------------------
module usbf_wb_slave_if #(
    parameter int ADDR_W  = 18,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic                  clk_i,
    input  logic                  wb_rst_n,
    input  logic [ADDR_W-1:0]     wb_addr_i,
    input  logic [DATA_W-1:0]     wb_data_i,
    input  logic [DATA_W/8-1:0]   wb_sel_i,
    input  logic                  wb_we_i,
    input  logic                  wb_stb_i,
    input  logic                  wb_cyc_i,
    output logic [DATA_W-1:0]     wb_data_o,
    output logic                  wb_ack_o,
    output logic                  wb_err_o,
    output logic [ADDR_W-1:0]     reg_addr_o,
    output logic [DATA_W-1:0]     reg_wdata_o,
    output logic [DATA_W/8-1:0]   reg_sel_o,
    output logic                  reg_we_o,
    output logic                  reg_re_o,
    input  logic [DATA_W-1:0]     reg_rdata_i,
    input  logic                  reg_rdy_i,
    output logic                  busy_o,
    output logic [7:0]            err_cnt_o
);

    localparam int SEL_W = DATA_W / 8;
    // A zero TIMEOUT would give a zero-width counter, so keep at least one bit.
    localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT);
    localparam bit TIMEOUT_EN = (TIMEOUT != 0);

    typedef enum logic [1:0] {IDLE, STRB, WAIT, TERM} state_t;

    state_t              state_q,    state_d;
    logic [CNT_W-1:0]    wait_cnt_q, wait_cnt_d;
    logic [ADDR_W-1:0]   addr_q,     addr_d;
    logic [DATA_W-1:0]   wdata_q,    wdata_d;
    logic [SEL_W-1:0]    sel_q,      sel_d;
    logic                we_lat_q,   we_lat_d;
    logic                reg_we_q,   reg_we_d;
    logic                reg_re_q,   reg_re_d;
    logic                ack_q,      ack_d;
    logic                err_q,      err_d;
    logic [DATA_W-1:0]   rdata_q,    rdata_d;
    logic [7:0]          err_cnt_q,  err_cnt_d;

    // Next-state and next-output logic. Strobes and terminations default low,
    // so each one is a single-cycle pulse. Dropping wb_cyc_i takes priority
    // over a completion: an abandoned cycle must never be acknowledged.
    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        sel_d      = sel_q;
        we_lat_d   = we_lat_q;
        rdata_d    = rdata_q;
        err_cnt_d  = err_cnt_q;
        reg_we_d   = 1'b0;
        reg_re_d   = 1'b0;
        ack_d      = 1'b0;
        err_d      = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (wb_cyc_i && wb_stb_i) begin
                    state_d  = STRB;
                    addr_d   = wb_addr_i;
                    wdata_d  = wb_data_i;
                    sel_d    = wb_sel_i;
                    we_lat_d = wb_we_i;
                    reg_we_d = wb_we_i;
                    reg_re_d = !wb_we_i;
                end
            end
            STRB: begin
                wait_cnt_d = '0;
                if (!wb_cyc_i) begin
                    state_d = IDLE;
                end else if (reg_rdy_i) begin
                    state_d = TERM;
                    ack_d   = 1'b1;
                    if (!we_lat_q) begin
                        rdata_d = reg_rdata_i;
                    end
                end else begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (!wb_cyc_i) begin
                    state_d = IDLE;
                end else if (reg_rdy_i) begin
                    // A completion on the timeout edge still wins.
                    state_d = TERM;
                    ack_d   = 1'b1;
                    if (!we_lat_q) begin
                        rdata_d = reg_rdata_i;
                    end
                end else if (TIMEOUT_EN && (wait_cnt_q == CNT_MAX)) begin
                    state_d = TERM;
                    err_d   = 1'b1;
                    rdata_d = '1;
                    if (err_cnt_q != 8'hFF) begin
                        err_cnt_d = err_cnt_q + 8'd1;
                    end
                end else if (wait_cnt_q != CNT_MAX) begin
                    wait_cnt_d = wait_cnt_q + 1'b1;
                end
            end
            TERM: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // All state and outputs are registered. Reset clears every output
    // immediately, so a pending strobe or termination is dropped.
    always_ff @(posedge clk_i or negedge wb_rst_n) begin
        if (!wb_rst_n) begin
            state_q    <= IDLE;
            wait_cnt_q <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
            sel_q      <= '0;
            we_lat_q   <= 1'b0;
            reg_we_q   <= 1'b0;
            reg_re_q   <= 1'b0;
            ack_q      <= 1'b0;
            err_q      <= 1'b0;
            rdata_q    <= '0;
            err_cnt_q  <= '0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            sel_q      <= sel_d;
            we_lat_q   <= we_lat_d;
            reg_we_q   <= reg_we_d;
            reg_re_q   <= reg_re_d;
            ack_q      <= ack_d;
            err_q      <= err_d;
            rdata_q    <= rdata_d;
            err_cnt_q  <= err_cnt_d;
        end
    end

    assign wb_data_o   = rdata_q;
    assign wb_ack_o    = ack_q;
    assign wb_err_o    = err_q;
    assign reg_addr_o  = addr_q;
    assign reg_wdata_o = wdata_q;
    assign reg_sel_o   = sel_q;
    assign reg_we_o    = reg_we_q;
    assign reg_re_o    = reg_re_q;
    assign busy_o      = (state_q != IDLE);
    assign err_cnt_o   = err_cnt_q;

endmodule

// File: tb/tb_usbf_wb_slave_if.sv
module tb_usbf_wb_slave_if;

   localparam int ADDR_W  = 18;
   localparam int DATA_W  = 32;
   localparam int SEL_W   = 4;
   localparam int TIMEOUT = 4;

   logic clock = 1'b0;
   logic resetN;
   logic [ADDR_W-1:0] wbAddr;
   logic [DATA_W-1:0] wbDataIn;
   logic [SEL_W-1:0]  wbSel;
   logic wbWe, wbStb, wbCyc;
   logic [DATA_W-1:0] wbDataOut;
   logic wbAck, wbErr;
   logic [ADDR_W-1:0] regAddr;
   logic [DATA_W-1:0] regWdata;
   logic [SEL_W-1:0]  regSel;
   logic regWe, regRe;
   logic [DATA_W-1:0] regRdata;
   logic regRdy;
   logic busy;
   logic [7:0] errCnt;

   int checkCount = 0;
   int errorCount = 0;

   // Reference state: what wb_data_o and err_cnt_o should hold between transfers.
   logic [DATA_W-1:0] expData = '0;
   int expErrCnt = 0;

   usbf_wb_slave_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT)) dut (
      .clk_i(clock), .wb_rst_n(resetN),
      .wb_addr_i(wbAddr), .wb_data_i(wbDataIn), .wb_sel_i(wbSel),
      .wb_we_i(wbWe), .wb_stb_i(wbStb), .wb_cyc_i(wbCyc),
      .wb_data_o(wbDataOut), .wb_ack_o(wbAck), .wb_err_o(wbErr),
      .reg_addr_o(regAddr), .reg_wdata_o(regWdata), .reg_sel_o(regSel),
      .reg_we_o(regWe), .reg_re_o(regRe),
      .reg_rdata_i(regRdata), .reg_rdy_i(regRdy),
      .busy_o(busy), .err_cnt_o(errCnt)
   );

   always #5 clock = ~clock;

   // Guard against a stuck run.
   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   // Single comparison point: counts every check and reports mismatches.
   task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
      checkCount++;
      if (actual !== expected) begin
         errorCount++;
         $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, actual, expected);
      end
   endtask

   // One bus transfer. lat = k means reg_rdy_i is sampled at edge N+1+k, and
   // lat < 0 means the core never answers. Expected timing comes straight from
   // the cycle rules: the ack is in cycle N+2+k when k <= TIMEOUT+1, and
   // otherwise the err is in cycle N+3+TIMEOUT. Called just after a falling
   // edge while the block is idle. If keep is set, the request stays
   // asserted afterwards.
   task automatic applyStimulus(input bit isWrite, input logic [ADDR_W-1:0] addr,
                                input logic [DATA_W-1:0] data, input logic [SEL_W-1:0] sel,
                                input int lat, input logic [DATA_W-1:0] rdata, input bit keep);
      bit isAck;
      int termC;
      isAck = (lat >= 0) && (lat <= TIMEOUT + 1);
      termC = isAck ? lat + 2 : TIMEOUT + 3;
      wbCyc = 1'b1; wbStb = 1'b1; wbWe = isWrite;
      wbAddr = addr; wbDataIn = data; wbSel = sel;
      @(posedge clock);
      for (int c = 1; c <= termC; c++) begin
         #1;
         regRdy   = (lat >= 0) && (c == lat + 1);
         regRdata = regRdy ? rdata : $urandom;
         wbDataIn = $urandom;
         wbAddr   = ADDR_W'($urandom);
         @(negedge clock);
         checkOutput("regWe", regWe, (c == 1) && isWrite);
         checkOutput("regRe", regRe, (c == 1) && !isWrite);
         checkOutput("ack", wbAck, (c == termC) && isAck);
         checkOutput("err", wbErr, (c == termC) && !isAck);
         checkOutput("busy", busy, 1);
         if (c == 1) begin
            checkOutput("regAddr", regAddr, addr);
            checkOutput("regWdata", regWdata, data);
            checkOutput("regSel", regSel, sel);
         end
         @(posedge clock);
      end
      #1;
      regRdy = 1'b0;
      if (!keep) begin
         wbCyc = 1'b0; wbStb = 1'b0;
      end else begin
         wbAddr = addr; wbDataIn = data;
      end
      if (isAck) begin
         if (!isWrite) expData = rdata;
      end else begin
         expData = '1;
         if (expErrCnt < 255) expErrCnt++;
      end
      @(negedge clock);
      checkOutput("idleBusy", busy, 0);
      checkOutput("idleAck", wbAck, 0);
      checkOutput("idleErr", wbErr, 0);
      checkOutput("dataOut", wbDataOut, expData);
      checkOutput("errCnt", errCnt, expErrCnt);
      checkOutput("regAddrHeld", regAddr, addr);
   endtask

   // Request dropped in WAIT at cycle N+abortC; late reg_rdy_i must be ignored.
   task automatic applyAbort(input int abortC, input logic [ADDR_W-1:0] addr);
      wbCyc = 1'b1; wbStb = 1'b1; wbWe = 1'b0;
      wbAddr = addr; wbDataIn = $urandom; wbSel = 4'hF;
      @(posedge clock);
      for (int c = 1; c <= abortC; c++) begin
         #1;
         regRdy = 1'b0;
         if (c == abortC) begin
            wbCyc = 1'b0; wbStb = 1'b0;
         end
         @(negedge clock);
         checkOutput("abortBusy", busy, 1);
         checkOutput("abortAck", wbAck, 0);
         checkOutput("abortErr", wbErr, 0);
         @(posedge clock);
      end
      for (int c = 1; c <= 4; c++) begin
         #1;
         regRdy = (c <= 2);
         regRdata = $urandom;
         @(negedge clock);
         checkOutput("lateBusy", busy, 0);
         checkOutput("lateAck", wbAck, 0);
         checkOutput("lateErr", wbErr, 0);
         @(posedge clock);
      end
      #1;
      regRdy = 1'b0;
      @(negedge clock);
      checkOutput("abortData", wbDataOut, expData);
      checkOutput("abortErrCnt", errCnt, expErrCnt);
   endtask

   initial begin
      bit w;
      int lat;
      resetN = 1'b0;
      wbCyc = 0; wbStb = 0; wbWe = 0; wbAddr = '0; wbDataIn = '0; wbSel = '0;
      regRdy = 0; regRdata = '0;
      #12;
      checkOutput("rstAck", wbAck, 0);
      checkOutput("rstErr", wbErr, 0);
      checkOutput("rstBusy", busy, 0);
      checkOutput("rstStrobes", {regWe, regRe}, 0);
      checkOutput("rstData", wbDataOut, 0);
      checkOutput("rstErrCnt", errCnt, 0);
      checkOutput("rstRegAddr", regAddr, 0);
      @(negedge clock);
      resetN = 1'b1;
      @(negedge clock);

      $display("[TB] directed transfers");
      applyStimulus(1'b1, 18'h00004, 32'hA5A5_0F0F, 4'b1111, 0, '0, 1'b0);
      applyStimulus(1'b0, 18'h00010, '0, 4'b1111, 5, 32'h1234_5678, 1'b0);
      applyStimulus(1'b0, 18'h00020, '0, 4'b1111, -1, '0, 1'b0);
      applyStimulus(1'b0, 18'h00024, '0, 4'b0011, TIMEOUT + 1, 32'hCAFE_BABE, 1'b0);
      applyStimulus(1'b0, 18'h00028, '0, 4'b1111, TIMEOUT + 2, 32'h0BAD_0BAD, 1'b0);

      $display("[TB] abort and back-to-back");
      applyAbort(2, 18'h00030);
      applyAbort(TIMEOUT + 1, 18'h00034);
      applyStimulus(1'b1, 18'h00040, 32'h1111_2222, 4'b0101, 0, '0, 1'b1);
      applyStimulus(1'b0, 18'h00044, '0, 4'b1111, 0, 32'h3333_4444, 1'b0);

      $display("[TB] randomized transfers");
      for (int i = 0; i < 60; i++) begin
         w   = 1'($urandom_range(0, 1));
         lat = w ? int'($urandom_range(0, TIMEOUT + 1)) : int'($urandom_range(0, TIMEOUT + 4));
         applyStimulus(w, ADDR_W'($urandom), $urandom, SEL_W'($urandom), lat, $urandom,
                       1'($urandom_range(0, 1)));
      end

      $display("[TB] error counter saturation");
      for (int i = 0; i < 300; i++) begin
         applyStimulus(1'b0, ADDR_W'(i), '0, 4'hF, -1, '0, 1'b0);
      end
      checkOutput("errCntSat", errCnt, 255);

      $display("[TB] asynchronous reset during WAIT");
      applyStimulus(1'b0, 18'h00050, '0, 4'hF, 0, 32'h7654_3210, 1'b0);
      wbCyc = 1'b1; wbStb = 1'b1; wbWe = 1'b0; wbAddr = 18'h00054; wbDataIn = 32'h5555_AAAA; wbSel = 4'hA;
      @(posedge clock);
      @(posedge clock);
      #2;
      resetN = 1'b0;
      #1;
      checkOutput("midRstBusy", busy, 0);
      checkOutput("midRstAckErr", {wbAck, wbErr}, 0);
      checkOutput("midRstStrobes", {regWe, regRe}, 0);
      checkOutput("midRstData", wbDataOut, 0);
      checkOutput("midRstErrCnt", errCnt, 0);
      checkOutput("midRstRegAddr", regAddr, 0);
      checkOutput("midRstRegWdata", regWdata, 0);
      checkOutput("midRstRegSel", regSel, 0);
      expData = '0;
      expErrCnt = 0;
      wbCyc = 1'b0; wbStb = 1'b0;
      @(negedge clock);
      resetN = 1'b1;
      @(negedge clock);
      applyStimulus(1'b0, 18'h00058, '0, 4'hF, 2, 32'hDEAD_BEEF, 1'b0);

      $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
      $finish;
   end

endmodule

// File: doc/usbf_wb_slave_if.md
# usbf_wb_slave_if

Parametrised Wishbone classic slave front end for the USB function core register space. It sits between the system Wishbone bus (`clk_i` domain) and the core's register/endpoint-buffer access port. It converts each `wb_cyc_i & wb_stb_i` cycle into a single-cycle read or write strobe, then waits for a core ready handshake of variable latency. It answers with `wb_ack_o`, or with `wb_err_o` if the wait exceeds a programmable timeout. It generalises the fixed 32-bit, ack-only bus of the previous generation: address/data width are parameters, byte selects are added, and an error termination and error counter are new.

## Interface
- `ADDR_W`, default 18: Wishbone and register address width.
- `DATA_W`, default 32: data width; must be a multiple of 8.
- `TIMEOUT`, default 255: maximum wait cycles for `reg_rdy_i`. A value of 0 disables the timeout.
- `clk_i` in 1: system clock; all logic is on its rising edge.
- `wb_rst_n` in 1: asynchronous active-low reset.
- `wb_addr_i` in ADDR_W: bus address.
- `wb_data_i` in DATA_W: write data.
- `wb_sel_i` in DATA_W/8: byte selects.
- `wb_we_i` in 1: 1 means write, 0 means read.
- `wb_stb_i` in 1: strobe.
- `wb_cyc_i` in 1: cycle valid.
- `wb_data_o` out DATA_W: read data, registered.
- `wb_ack_o` out 1: normal termination.
- `wb_err_o` out 1: error (timeout) termination.
- `reg_addr_o` out ADDR_W: latched address.
- `reg_wdata_o` out DATA_W: latched write data.
- `reg_sel_o` out DATA_W/8: latched byte selects.
- `reg_we_o` out 1: one-cycle write strobe.
- `reg_re_o` out 1: one-cycle read strobe.
- `reg_rdata_i` in DATA_W: core read data, valid with `reg_rdy_i`.
- `reg_rdy_i` in 1: core completion, one cycle.
- `busy_o` out 1: high whenever state ≠ IDLE.
- `err_cnt_o` out 8: saturating count of timeouts.

## Operation
- The FSM has four states: IDLE, STRB, WAIT, TERM.
- IDLE: on an edge with `wb_cyc_i & wb_stb_i` high, latch addr, data and sel. Go to STRB.
- STRB, one cycle: `reg_we_o` = latched we; `reg_re_o` = !latched we. Clear the wait counter.
- STRB next state:
  - `reg_rdy_i` sampled high in STRB: go to TERM with ack.
  - otherwise: go to WAIT.
- WAIT: the wait counter increments each cycle. It is `$clog2(TIMEOUT+1)` bits wide and saturates at TIMEOUT.
  - `reg_rdy_i` high: go to TERM with ack. For a read, capture `reg_rdata_i` into `wb_data_o`.
  - Counter == TIMEOUT and TIMEOUT ≠ 0, with no `reg_rdy_i`: go to TERM with err. Set `wb_data_o` to all-ones. Increment `err_cnt_o`, saturating at 255.
  - `reg_rdy_i` and timeout in the same cycle: `reg_rdy_i` wins, so the transfer terminates with ack.
- TERM, one cycle: exactly one of `wb_ack_o` / `wb_err_o` is high. Next state is IDLE unconditionally.
  - A still-asserted `wb_stb_i` is not accepted until the following IDLE edge. There is one turnaround cycle.
- Abort: `wb_cyc_i` low in STRB or WAIT returns to IDLE with no termination.
  - A `reg_rdy_i` that arrives later while in IDLE is ignored.
- For writes, `wb_data_o` holds its previous value.
- `reg_rdy_i` is ignored in IDLE and TERM.

## Timing
- Reset values: all outputs are 0, FSM is in IDLE, counters are 0.
- Reset is asynchronous mid-transfer: any pending strobe or ack is dropped immediately.
- Cycle numbering: the request is sampled at edge N.
  - `reg_we_o`/`reg_re_o` are high in cycle N+1.
  - If `reg_rdy_i` is sampled at edge N+1+k, the ack is high in cycle N+2+k.
- Minimum latency is 2 cycles, from request edge to ack cycle.
- Minimum back-to-back request spacing is 3 cycles.
- Timeout: with no `reg_rdy_i`, `wb_err_o` is high in cycle N+3+TIMEOUT.
- `wb_ack_o` and `wb_err_o` are never high together, never high for 2 consecutive cycles, and never high outside TERM.
- `reg_*` outputs hold their latched values from STRB until the next accepted request.

## Test plan
- Write: addr `0x00004`, data `0xA5A5_0F0F`, sel `4'b1111`, core `reg_rdy_i` in STRB → `reg_we_o` pulse in cycle N+1 with latched values; `wb_ack_o` in cycle N+2; `wb_data_o` unchanged.
- Read with latency 5: `reg_rdy_i` is sampled at edge N+6, with `reg_rdata_i` = `0x1234_5678` → `wb_ack_o` in cycle N+7; `wb_data_o` = `0x1234_5678`; `busy_o` is high from N+1 through N+7.
- Timeout: TIMEOUT = 4, read, `reg_rdy_i` never asserted → `wb_err_o` in cycle N+7; `wb_data_o` = `0xFFFF_FFFF`; `err_cnt_o` = 1. After 300 such timeouts, `err_cnt_o` = 255.
- Simultaneous: `reg_rdy_i` arrives at the exact timeout edge → `wb_ack_o` with the core data; `err_cnt_o` unchanged.
- Abort and back-to-back:
  - `wb_cyc_i` dropped in WAIT → no ack or err; a later `reg_rdy_i` is ignored.
  - `wb_stb_i` held across two requests → the second is accepted 3 cycles after the first.
- Reset: `wb_rst_n` pulsed low during WAIT → all outputs are 0 asynchronously; after release, a new request completes normally.
